// File: rtl/dsp_tx_divbank.sv
// Bank of NCH runtime-programmable clock dividers (square / pulse / one-shot) plus heartbeat LEDs.
// New configs wait in a per-channel pending slot and are applied only at waveform boundaries.
module dsp_tx_divbank #(
  parameter int NCH   = 4,
  parameter int DIV_W = 16,
  parameter int HB_W  = 28
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [$clog2(NCH)-1:0] cfg_ch,
  input  logic [1:0]             cfg_mode,
  input  logic [DIV_W-1:0]       cfg_div,
  output logic [NCH-1:0]         sq_out,
  output logic [NCH-1:0]         wrap_pulse,
  output logic [1:0]             led
);

  localparam int CH_W = $clog2(NCH);

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_SQUARE  = 2'd1,
    MODE_PULSE   = 2'd2,
    MODE_ONESHOT = 2'd3
  } mode_e;

  mode_e            mode_q  [NCH];
  mode_e            mode_d  [NCH];
  mode_e            pmode_q [NCH];
  mode_e            pmode_d [NCH];
  logic [DIV_W-1:0] div_q   [NCH];
  logic [DIV_W-1:0] div_d   [NCH];
  logic [DIV_W-1:0] pdiv_q  [NCH];
  logic [DIV_W-1:0] pdiv_d  [NCH];
  logic [DIV_W-1:0] cnt_q   [NCH];
  logic [DIV_W-1:0] cnt_d   [NCH];
  logic [NCH-1:0]   sq_q, sq_d;
  logic [NCH-1:0]   wrap_q, wrap_d;
  logic [NCH-1:0]   pend_q, pend_d;
  logic [NCH-1:0]   hit, bnd;
  logic [HB_W-1:0]  hb_q, hb_d;

  assign cfg_ready  = ~pend_q[cfg_ch];
  assign sq_out     = sq_q;
  assign wrap_pulse = wrap_q;
  assign led        = {~hb_q[HB_W-1], hb_q[HB_W-1]};

  always_comb begin
    mode_d  = mode_q;
    pmode_d = pmode_q;
    div_d   = div_q;
    pdiv_d  = pdiv_q;
    cnt_d   = cnt_q;
    sq_d    = sq_q;
    wrap_d  = '0;
    pend_d  = pend_q;
    hit     = '0;
    bnd     = '0;
    hb_d    = hb_q + 1'b1;

    for (int unsigned i = 0; i < NCH; i++) begin
      hit[i] = (mode_q[i] != MODE_OFF) && (cnt_q[i] == div_q[i]);
      case (mode_q[i])
        MODE_OFF:    bnd[i] = 1'b1;
        MODE_SQUARE: bnd[i] = hit[i] & sq_q[i];
        default:     bnd[i] = hit[i];
      endcase

      if (mode_q[i] == MODE_OFF) begin
        cnt_d[i] = '0;
        sq_d[i]  = 1'b0;
      end else if (hit[i]) begin
        cnt_d[i]  = '0;
        wrap_d[i] = 1'b1;
        case (mode_q[i])
          MODE_SQUARE: sq_d[i] = ~sq_q[i];
          MODE_PULSE:  sq_d[i] = 1'b1;
          default: begin
            sq_d[i]   = 1'b0;
            mode_d[i] = MODE_OFF;
          end
        endcase
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
        if (mode_q[i] == MODE_PULSE) sq_d[i] = 1'b0;
      end

      // A boundary wrap still completes the running waveform for same-mode
      // rewrites (square falls, pulse fires), so phase carries on without a runt.
      if (pend_q[i] && bnd[i]) begin
        cnt_d[i]  = '0;
        mode_d[i] = pmode_q[i];
        div_d[i]  = pdiv_q[i];
        pend_d[i] = 1'b0;
        case (pmode_q[i])
          MODE_SQUARE:  sq_d[i] = (mode_q[i] != MODE_SQUARE);
          MODE_PULSE:   sq_d[i] = (mode_q[i] == MODE_PULSE);
          MODE_ONESHOT: sq_d[i] = 1'b1;
          default:      sq_d[i] = 1'b0;
        endcase
      end

      if (cfg_valid && cfg_ready && (cfg_ch == CH_W'(i))) begin
        pend_d[i]  = 1'b1;
        pmode_d[i] = mode_e'(cfg_mode);
        pdiv_d[i]  = cfg_div;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        mode_q[i]  <= MODE_OFF;
        pmode_q[i] <= MODE_OFF;
        div_q[i]   <= '0;
        pdiv_q[i]  <= '0;
        cnt_q[i]   <= '0;
      end
      sq_q   <= '0;
      wrap_q <= '0;
      pend_q <= '0;
      hb_q   <= '0;
    end else begin
      for (int unsigned i = 0; i < NCH; i++) begin
        mode_q[i]  <= mode_d[i];
        pmode_q[i] <= pmode_d[i];
        div_q[i]   <= div_d[i];
        pdiv_q[i]  <= pdiv_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      sq_q   <= sq_d;
      wrap_q <= wrap_d;
      pend_q <= pend_d;
      hb_q   <= hb_d;
    end
  end

endmodule

// File: tb/tb_dsp_tx_divbank.sv
// Directed bench for dsp_tx_divbank: square/pulse/one-shot timing, boundary-deferred
// reconfiguration, asynchronous reset and heartbeat LED (HB_W=4).
module tb_dsp_tx_divbank;

  localparam int NCH   = 4;
  localparam int DIV_W = 16;
  localparam int HB_W  = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cfg_valid = 1'b0;
  logic             cfg_ready;
  logic [1:0]       cfg_ch = '0;
  logic [1:0]       cfg_mode = '0;
  logic [DIV_W-1:0] cfg_div = '0;
  logic [NCH-1:0]   sq_out;
  logic [NCH-1:0]   wrap_pulse;
  logic [1:0]       led;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  dsp_tx_divbank #(.NCH(NCH), .DIV_W(DIV_W), .HB_W(HB_W)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_mode(cfg_mode), .cfg_div(cfg_div),
    .sq_out(sq_out), .wrap_pulse(wrap_pulse), .led(led)
  );

  // Called at a negedge; the write is accepted on the following posedge.
  task automatic send(input logic [1:0] ch, input logic [1:0] mode, input logic [DIV_W-1:0] div);
    cfg_valid = 1'b1;
    cfg_ch    = ch;
    cfg_mode  = mode;
    cfg_div   = div;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    vec_cnt++;
    if (sq_out !== 4'b0000) begin err_cnt++; $display("FAIL reset_sq got=%b exp=0000", sq_out); end
    vec_cnt++;
    if (wrap_pulse !== 4'b0000) begin err_cnt++; $display("FAIL reset_wrap got=%b exp=0000", wrap_pulse); end
    vec_cnt++;
    if (led !== 2'b10) begin err_cnt++; $display("FAIL reset_led got=%b exp=10", led); end
    vec_cnt++;
    if (cfg_ready !== 1'b1) begin err_cnt++; $display("FAIL reset_ready got=%b exp=1", cfg_ready); end
    rst = 1'b0;
  endtask

  task automatic test_square();
    logic es, ew;
    send(2'd0, 2'd1, 16'd3);
    vec_cnt++;
    if (cfg_ready !== 1'b0) begin err_cnt++; $display("FAIL sq_pending_ready got=%b exp=0", cfg_ready); end
    vec_cnt++;
    if (sq_out[0] !== 1'b0) begin err_cnt++; $display("FAIL sq_before_apply got=%b exp=0", sq_out[0]); end
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      es = (((k - 1) / 4) % 2) == 0;
      ew = (k >= 5) && ((k % 4) == 1);
      vec_cnt++;
      if (sq_out[0] !== es) begin err_cnt++; $display("FAIL sq_wave k=%0d got=%b exp=%b", k, sq_out[0], es); end
      vec_cnt++;
      if (wrap_pulse[0] !== ew) begin err_cnt++; $display("FAIL sq_wrap k=%0d got=%b exp=%b", k, wrap_pulse[0], ew); end
      if (k == 1) begin
        vec_cnt++;
        if (cfg_ready !== 1'b1) begin err_cnt++; $display("FAIL sq_ready_after got=%b exp=1", cfg_ready); end
      end
    end
  endtask

  task automatic test_rewrite();
    logic found, es, ew, er;
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      @(negedge clk);
      if (wrap_pulse[0] && sq_out[0]) found = 1'b1;
    end
    vec_cnt++;
    if (!found) begin err_cnt++; $display("FAIL rw_find_high got=timeout exp=rising edge"); end
    send(2'd0, 2'd1, 16'd1);
    for (int j = 1; j <= 15; j++) begin
      if (j > 1) @(negedge clk);
      es = (j <= 3) ? 1'b1 : ((((j - 4) / 2) % 2) == 1);
      ew = (j >= 4) && ((j % 2) == 0);
      vec_cnt++;
      if (sq_out[0] !== es) begin err_cnt++; $display("FAIL rw_wave j=%0d got=%b exp=%b", j, sq_out[0], es); end
      vec_cnt++;
      if (wrap_pulse[0] !== ew) begin err_cnt++; $display("FAIL rw_wrap j=%0d got=%b exp=%b", j, wrap_pulse[0], ew); end
      if (j <= 4) begin
        er = (j == 4);
        vec_cnt++;
        if (cfg_ready !== er) begin err_cnt++; $display("FAIL rw_ready j=%0d got=%b exp=%b", j, cfg_ready, er); end
      end
    end
  endtask

  task automatic test_pulse();
    logic e;
    send(2'd1, 2'd2, 16'd0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      e = (k >= 2);
      vec_cnt++;
      if (sq_out[1] !== e) begin err_cnt++; $display("FAIL p0_sq k=%0d got=%b exp=%b", k, sq_out[1], e); end
      vec_cnt++;
      if (wrap_pulse[1] !== e) begin err_cnt++; $display("FAIL p0_wrap k=%0d got=%b exp=%b", k, wrap_pulse[1], e); end
    end
    send(2'd1, 2'd2, 16'd4);
    vec_cnt++;
    if (cfg_ready !== 1'b0) begin err_cnt++; $display("FAIL p4_pending_ready got=%b exp=0", cfg_ready); end
    vec_cnt++;
    if (sq_out[1] !== 1'b1) begin err_cnt++; $display("FAIL p4_accept_sq got=%b exp=1", sq_out[1]); end
    for (int m = 1; m <= 15; m++) begin
      @(negedge clk);
      e = ((m - 1) % 5) == 0;
      vec_cnt++;
      if (sq_out[1] !== e) begin err_cnt++; $display("FAIL p4_sq m=%0d got=%b exp=%b", m, sq_out[1], e); end
      vec_cnt++;
      if (wrap_pulse[1] !== e) begin err_cnt++; $display("FAIL p4_wrap m=%0d got=%b exp=%b", m, wrap_pulse[1], e); end
      if (m == 1) begin
        vec_cnt++;
        if (cfg_ready !== 1'b1) begin err_cnt++; $display("FAIL p4_ready got=%b exp=1", cfg_ready); end
      end
    end
  endtask

  task automatic test_oneshot();
    logic es, ew;
    send(2'd2, 2'd3, 16'd9);
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      es = (k <= 10);
      ew = (k == 11);
      vec_cnt++;
      if (sq_out[2] !== es) begin err_cnt++; $display("FAIL os_sq k=%0d got=%b exp=%b", k, sq_out[2], es); end
      vec_cnt++;
      if (wrap_pulse[2] !== ew) begin err_cnt++; $display("FAIL os_wrap k=%0d got=%b exp=%b", k, wrap_pulse[2], ew); end
      if (k == 1 || k == 14) begin
        vec_cnt++;
        if (cfg_ready !== 1'b1) begin err_cnt++; $display("FAIL os_ready k=%0d got=%b exp=1", k, cfg_ready); end
      end
    end
    send(2'd2, 2'd1, 16'd2);
    vec_cnt++;
    if (sq_out[2] !== 1'b0) begin err_cnt++; $display("FAIL os_new_accept got=%b exp=0", sq_out[2]); end
    @(negedge clk);
    vec_cnt++;
    if (sq_out[2] !== 1'b1) begin err_cnt++; $display("FAIL os_new_apply got=%b exp=1", sq_out[2]); end
  endtask

  task automatic test_back_to_back();
    logic es, er;
    send(2'd3, 2'd2, 16'd2);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      es = (k == 4);
      vec_cnt++;
      if (sq_out[3] !== es) begin err_cnt++; $display("FAIL bb_pre k=%0d got=%b exp=%b", k, sq_out[3], es); end
    end
    send(2'd3, 2'd2, 16'd1);
    vec_cnt++;
    if (sq_out[3] !== 1'b1) begin err_cnt++; $display("FAIL bb_coinc_sq got=%b exp=1", sq_out[3]); end
    vec_cnt++;
    if (wrap_pulse[3] !== 1'b1) begin err_cnt++; $display("FAIL bb_coinc_wrap got=%b exp=1", wrap_pulse[3]); end
    vec_cnt++;
    if (cfg_ready !== 1'b0) begin err_cnt++; $display("FAIL bb_ch3_ready got=%b exp=0", cfg_ready); end
    cfg_ch = 2'd0;
    #1;
    vec_cnt++;
    if (cfg_ready !== 1'b1) begin err_cnt++; $display("FAIL bb_ch0_ready got=%b exp=1", cfg_ready); end
    send(2'd0, 2'd1, 16'd3);
    cfg_ch = 2'd3;
    #1;
    for (int k = 8; k <= 14; k++) begin
      if (k > 8) @(negedge clk);
      es = (k >= 10) && ((k % 2) == 0);
      er = (k >= 10);
      vec_cnt++;
      if (sq_out[3] !== es) begin err_cnt++; $display("FAIL bb_post k=%0d got=%b exp=%b", k, sq_out[3], es); end
      vec_cnt++;
      if (cfg_ready !== er) begin err_cnt++; $display("FAIL bb_ready k=%0d got=%b exp=%b", k, cfg_ready, er); end
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0] el;
    send(2'd1, 2'd1, 16'd200);
    repeat (10) @(negedge clk);
    vec_cnt++;
    if (sq_out[1] !== 1'b1) begin err_cnt++; $display("FAIL rm_long_high got=%b exp=1", sq_out[1]); end
    send(2'd1, 2'd1, 16'd5);
    vec_cnt++;
    if (cfg_ready !== 1'b0) begin err_cnt++; $display("FAIL rm_pending got=%b exp=0", cfg_ready); end
    #2 rst = 1'b1;
    #1;
    vec_cnt++;
    if (sq_out !== 4'b0000) begin err_cnt++; $display("FAIL rm_sq got=%b exp=0000", sq_out); end
    vec_cnt++;
    if (wrap_pulse !== 4'b0000) begin err_cnt++; $display("FAIL rm_wrap got=%b exp=0000", wrap_pulse); end
    vec_cnt++;
    if (led !== 2'b10) begin err_cnt++; $display("FAIL rm_led got=%b exp=10", led); end
    vec_cnt++;
    if (cfg_ready !== 1'b1) begin err_cnt++; $display("FAIL rm_ready got=%b exp=1", cfg_ready); end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      el = ((k % 16) >= 8) ? 2'b01 : 2'b10;
      vec_cnt++;
      if (led !== el) begin err_cnt++; $display("FAIL hb_led k=%0d got=%b exp=%b", k, led, el); end
      if (k <= 4) begin
        vec_cnt++;
        if (sq_out !== 4'b0000) begin err_cnt++; $display("FAIL rm_discard k=%0d got=%b exp=0000", k, sq_out); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_square();
    test_rewrite();
    test_pulse();
    test_oneshot();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
